// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic sequencer and array.
// Holds the sequencer state enum, mode bit positions and wavefront range test.
package systolic_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_B,
    S_CLEAR,
    S_COMPUTE,
    S_DRAIN,
    S_DONE
  } seq_state_t;

  localparam int MODE_SKIP_W = 0;
  localparam int MODE_SKIP_B = 1;

  // PE `pe` accumulates while the beat index lies in [pe, pe+len).
  function automatic logic wavefront_mask(
    input int unsigned pe,
    input int unsigned cnt,
    input int unsigned len
  );
    return (cnt >= pe) && (cnt < pe + len);
  endfunction

endpackage

// File: rtl/systolic_sequencer_onehot_dec.sv
// Index to one-hot decoder with enable.
// Ports: i_idx index, i_en enable, o_onehot decoded vector (zero when disabled).
module onehot_dec #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [W-1:0] i_idx,
  input  logic         i_en,
  output logic [N-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_idx] = 1'b1;
  end

endmodule

// File: rtl/systolic_sequencer.sv
// Job sequencer for an N_PE linear systolic array: load W, load B, clear,
// compute wavefront and drain, with valid/ready on input stream and drain.
// Ports: clk/rst_n (sync, active-low), start/mode/k_len job request,
// in_valid/in_ready input stream, pe_*_en per-PE enables, acc_clr,
// drain_sel/out_valid/out_ready drain port, busy and done status.
module systolic_sequencer
  import systolic_pkg::*;
#(
  parameter int N_PE  = 8,
  parameter int LEN_W = 5,
  parameter int SEL_W = $clog2(N_PE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [LEN_W-1:0] k_len,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N_PE-1:0]  pe_weight_en,
  output logic [N_PE-1:0]  pe_bias_en,
  output logic [N_PE-1:0]  pe_acc_en,
  output logic             acc_clr,
  output logic [SEL_W-1:0] drain_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(2**LEN_W + N_PE);
  localparam logic [CNT_W-1:0] LAST_PE = CNT_W'(N_PE - 1);

  seq_state_t       r_state;
  seq_state_t       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_mode;
  logic [LEN_W-1:0] r_klen;
  logic [CNT_W-1:0] w_klen;
  logic [CNT_W-1:0] w_cmp_end;
  logic             w_adv;
  logic             w_dec_en;
  logic [N_PE-1:0]  w_onehot;

  assign w_klen    = CNT_W'(r_klen);
  assign w_cmp_end = w_klen + CNT_W'(N_PE - 2);

  // One decoder serves both load phases; the state picks the target bus.
  onehot_dec #(.N(N_PE), .W(SEL_W)) u_dec (
    .i_idx    (r_cnt[SEL_W-1:0]),
    .i_en     (w_dec_en),
    .o_onehot (w_onehot)
  );

  always_comb begin
    w_next       = r_state;
    w_adv        = 1'b0;
    w_dec_en     = 1'b0;
    in_ready     = 1'b0;
    pe_weight_en = '0;
    pe_bias_en   = '0;
    pe_acc_en    = '0;
    acc_clr      = 1'b0;
    drain_sel    = '0;
    out_valid    = 1'b0;
    busy         = (r_state != S_IDLE);
    done         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (!mode[MODE_SKIP_W])      w_next = S_LOAD_W;
          else if (!mode[MODE_SKIP_B]) w_next = S_LOAD_B;
          else                         w_next = S_CLEAR;
        end
      end
      S_LOAD_W: begin
        in_ready     = 1'b1;
        w_adv        = in_valid;
        w_dec_en     = in_valid;
        pe_weight_en = w_onehot;
        if (w_adv && r_cnt == LAST_PE)
          w_next = r_mode[MODE_SKIP_B] ? S_CLEAR : S_LOAD_B;
      end
      S_LOAD_B: begin
        in_ready   = 1'b1;
        w_adv      = in_valid;
        w_dec_en   = in_valid;
        pe_bias_en = w_onehot;
        if (w_adv && r_cnt == LAST_PE) w_next = S_CLEAR;
      end
      S_CLEAR: begin
        acc_clr = 1'b1;
        w_next  = (r_klen == '0) ? S_DRAIN : S_COMPUTE;
      end
      S_COMPUTE: begin
        // Feed beats wait for data; flush beats free-run.
        in_ready = (r_cnt < w_klen);
        w_adv    = in_ready ? in_valid : 1'b1;
        if (w_adv) begin
          for (int unsigned i = 0; i < N_PE; i++)
            pe_acc_en[i] = wavefront_mask(i, 32'(r_cnt), 32'(r_klen));
        end
        if (w_adv && r_cnt == w_cmp_end) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        drain_sel = r_cnt[SEL_W-1:0];
        w_adv     = out_ready;
        if (w_adv && r_cnt == LAST_PE) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_mode  <= '0;
      r_klen  <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_cnt <= '0;
      else if (w_adv)        r_cnt <= r_cnt + CNT_W'(1);
      if (r_state == S_IDLE && start) begin
        r_mode <= mode;
        r_klen <= k_len;
      end
    end
  end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed testbench for systolic_sequencer (N_PE=8, LEN_W=5).
// Runs whole jobs cycle by cycle and checks enables, drain and done timing.
module tb_systolic_sequencer;

  localparam int N_PE  = 8;
  localparam int LEN_W = 5;
  localparam int SEL_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [1:0]       mode;
  logic [LEN_W-1:0] k_len;
  logic             in_valid;
  logic             in_ready;
  logic [N_PE-1:0]  pe_weight_en;
  logic [N_PE-1:0]  pe_bias_en;
  logic [N_PE-1:0]  pe_acc_en;
  logic             acc_clr;
  logic [SEL_W-1:0] drain_sel;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;

  systolic_sequencer #(.N_PE(N_PE), .LEN_W(LEN_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .mode         (mode),
    .k_len        (k_len),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .pe_weight_en (pe_weight_en),
    .pe_bias_en   (pe_bias_en),
    .pe_acc_en    (pe_acc_en),
    .acc_clr      (acc_clr),
    .drain_sel    (drain_sel),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] w_seq[$];
  logic [7:0] b_seq[$];
  logic [7:0] a_seq[$];
  logic [2:0] d_seq[$];
  int clr_cnt;
  int clr_cyc;
  int done_cnt;
  int done_cyc;

  logic [7:0] acc_nom[16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F,
                              8'h7F, 8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0,
                              8'hE0, 8'hC0, 8'h80, 8'h00};
  logic [7:0] acc_k3[16]  = '{8'h01, 8'h03, 8'h07, 8'h0E, 8'h1C, 8'h38,
                              8'h70, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h00,
                              8'h00, 8'h00, 8'h00, 8'h00};

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({in_ready, pe_weight_en, pe_bias_en, pe_acc_en, acc_clr,
                drain_sel, out_valid, busy, done});
  endfunction

  // Drives one job from IDLE to DONE; cycle 1 is the first busy cycle.
  task automatic run_job(input string nm, input logic [1:0] m,
                         input logic [LEN_W-1:0] kl,
                         input logic [63:0] ivl, input logic [63:0] orl,
                         input int bsy_cyc, input int exp_done);
    logic [2:0] held = '0;
    logic       hold = 1'b0;
    int         c    = 0;
    int         nz;
    w_seq.delete(); b_seq.delete(); a_seq.delete(); d_seq.delete();
    clr_cnt = 0; clr_cyc = -1; done_cnt = 0; done_cyc = -1;
    start = 1'b1; mode = m; k_len = kl; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({nm, "/idle_busy"}, 64'(busy), 64'd0);
    while (done_cyc < 0 && c < 120) begin
      cyc();
      c++;
      start     = (c == bsy_cyc);
      k_len     = (c == bsy_cyc) ? 5'd5 : kl;
      mode      = (c == bsy_cyc) ? 2'b00 : m;
      in_valid  = !((c < 64) && ivl[c]);
      out_ready = !((c < 64) && orl[c]);
      #1;
      if (pe_weight_en != '0) w_seq.push_back(pe_weight_en);
      if (pe_bias_en != '0)   b_seq.push_back(pe_bias_en);
      if (pe_acc_en != '0)    a_seq.push_back(pe_acc_en);
      if (acc_clr) begin clr_cnt++; clr_cyc = c; end
      if (out_valid && out_ready) d_seq.push_back(drain_sel);
      if (hold) chk({nm, "/drain_hold"}, 64'(drain_sel), 64'(held));
      hold = out_valid && !out_ready;
      held = drain_sel;
      if (!in_valid && in_ready)
        chk({nm, "/stall_en"},
            64'({pe_weight_en, pe_bias_en, pe_acc_en}), 64'd0);
      nz = int'(pe_weight_en != '0) + int'(pe_bias_en != '0) +
           int'(pe_acc_en != '0);
      chk({nm, "/en_excl"}, 64'(nz <= 1), 64'd1);
      chk({nm, "/busy"}, 64'(busy), 64'd1);
      if (done) begin done_cnt++; done_cyc = c; end
    end
    start = 1'b0; mode = m; k_len = kl;
    chk({nm, "/done_cyc"}, 64'(done_cyc), 64'(exp_done));
    repeat (3) begin
      cyc(); #1;
      chk({nm, "/post_busy"}, 64'(busy), 64'd0);
      chk({nm, "/post_done"}, 64'(done), 64'd0);
    end
  endtask

  task automatic chk_seqs(input string nm, input int nw,
                          input logic [7:0] e[16], input int na);
    logic [7:0] one = 8'h01;
    chk({nm, "/w_n"}, 64'(w_seq.size()), 64'(nw));
    chk({nm, "/b_n"}, 64'(b_seq.size()), 64'(nw));
    for (int i = 0; i < nw && i < w_seq.size(); i++)
      chk({nm, "/w_val"}, 64'(w_seq[i]), 64'(one << i));
    for (int i = 0; i < nw && i < b_seq.size(); i++)
      chk({nm, "/b_val"}, 64'(b_seq[i]), 64'(one << i));
    chk({nm, "/acc_n"}, 64'(a_seq.size()), 64'(na));
    for (int i = 0; i < na && i < a_seq.size(); i++)
      chk({nm, "/acc_val"}, 64'(a_seq[i]), 64'(e[i]));
    chk({nm, "/drain_n"}, 64'(d_seq.size()), 64'd8);
    for (int i = 0; i < d_seq.size(); i++)
      chk({nm, "/drain_sel"}, 64'(d_seq[i]), 64'(i));
    chk({nm, "/clr_n"}, 64'(clr_cnt), 64'd1);
    chk({nm, "/done_n"}, 64'(done_cnt), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = '0; k_len = '0;
    in_valid = 1'b1; out_ready = 1'b1;
    cyc(); cyc(); #1;
    chk("rst_outs", all_outs(), 64'd0);
    rst_n = 1'b1;
    cyc();

    run_job("nom", 2'b00, 5'd8, 64'd0, 64'd0, 0, 41);
    chk_seqs("nom", 8, acc_nom, 15);
    chk("nom/clr_cyc", 64'(clr_cyc), 64'd17);

    run_job("reuse", 2'b11, 5'd3, 64'd0, 64'd0, 0, 20);
    chk_seqs("reuse", 0, acc_k3, 10);
    chk("reuse/clr_cyc", 64'(clr_cyc), 64'd1);

    run_job("bp", 2'b00, 5'd8,
            (64'd1 << 5) | (64'd1 << 6) | (64'd1 << 21) | (64'd1 << 22),
            (64'd1 << 42), 0, 46);
    chk_seqs("bp", 8, acc_nom, 15);
    chk("bp/clr_cyc", 64'(clr_cyc), 64'd19);

    run_job("zero", 2'b11, 5'd0, 64'd0, 64'd0, 0, 10);
    chk_seqs("zero", 0, acc_k3, 0);
    chk("zero/clr_cyc", 64'(clr_cyc), 64'd1);

    run_job("sbusy", 2'b11, 5'd3, 64'd0, 64'd0, 13, 20);
    chk_seqs("sbusy", 0, acc_k3, 10);

    run_job("wrap", 2'b11, 5'd31, 64'd0, 64'd0, 0, 48);
    chk("wrap/acc_n", 64'(a_seq.size()), 64'd38);
    chk("wrap/acc_last", 64'(a_seq[a_seq.size()-1]), 64'h80);
    chk("wrap/drain_n", 64'(d_seq.size()), 64'd8);

    start = 1'b1; mode = 2'b11; k_len = 5'd8;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    cyc(); start = 1'b0; #1;
    chk("mid/clr", 64'(acc_clr), 64'd1);
    cyc(); cyc(); cyc(); #1;
    chk("mid/acc", 64'(pe_acc_en), 64'h07);
    rst_n = 1'b0;
    cyc(); #1;
    chk("mid/rst_outs", all_outs(), 64'd0);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (10) begin
      cyc(); #1;
      done_cnt += int'(done);
      chk("mid/idle_busy", 64'(busy), 64'd0);
    end
    chk("mid/no_done", 64'(done_cnt), 64'd0);

    run_job("after", 2'b11, 5'd3, 64'd0, 64'd0, 0, 20);
    chk_seqs("after", 0, acc_k3, 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
